fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_3000, meaning the address of the first fetch after reset.
REQ-002 The block SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 The block SHALL have port imem_req  output  1  instruction-memory read request.
REQ-005 The block SHALL have port imem_addr  output  32  word address of the outstanding request.
REQ-006 The block SHALL have port imem_ack  input  1  one-cycle pulse; imem_rdata is valid in the same cycle.
REQ-007 The block SHALL have port imem_rdata  input  32  fetched instruction word.
REQ-008 The block SHALL have port instr  output  32  instruction presented to decode.
REQ-009 The block SHALL have port pc_out  output  32  address of the presented instruction.
REQ-010 The block SHALL have port opcode  output  6  equal to instr[31:26], feeding the control decoder OpCode input.
REQ-011 The block SHALL have port funct  output  6  equal to instr[5:0], feeding the control decoder Funct input.
REQ-012 The block SHALL have port instr_valid  output  1  instr/pc_out are valid.
REQ-013 The block SHALL have port instr_ready  input  1  decode accepts instr this cycle.
REQ-014 The block SHALL have port redirect  input  1  branch/jump taken; refetch from redirect_pc.
REQ-015 The block SHALL have port redirect_pc  input  32  redirect target.

Function
REQ-016 The block SHALL implement states IDLE, REQ, HOLD and DROP, with the fetch PC held in an internal 32-bit register pc.
REQ-017 In IDLE, with no redirect, the block SHALL drive imem_req=1 and imem_addr=pc on the next cycle and move to REQ.
REQ-018 In REQ, imem_req SHALL stay 1 and imem_addr SHALL stay stable until imem_ack.
REQ-019 On imem_ack in REQ without redirect, the block SHALL set instr=imem_rdata, pc_out=pc, instr_valid=1 and pc=pc+4 on the next edge, with imem_req=0 from that edge, and move to HOLD; latency is ack cycle N -> instr_valid cycle N+1.
REQ-020 In HOLD, instr, pc_out and instr_valid SHALL stay stable until instr_valid&&instr_ready.
REQ-021 On that handshake, instr_valid SHALL go 0 on the next edge, with imem_req=1 at the new pc on the same edge, and the state SHALL move to REQ.
REQ-022 pc+4 SHALL wrap modulo 2^32, so 32'hFFFF_FFFC -> 32'h0000_0000.
REQ-023 redirect SHALL take priority over every other event; pc SHALL load {redirect_pc[31:2],2'b00}, with the low bits forced to zero.
REQ-024 A redirect in IDLE or HOLD SHALL clear instr_valid and move to IDLE, so that imem_req is low for exactly one cycle before the new fetch.
REQ-025 A redirect in HOLD coincident with the instr handshake SHALL count the instruction as consumed, and redirect_pc SHALL still win.
REQ-026 A redirect in REQ without imem_ack SHALL move to DROP, while imem_req stays 1 and imem_addr keeps the old address until ack.
REQ-027 A redirect in REQ coincident with imem_ack SHALL discard the data, keep instr_valid 0 and move to IDLE.
REQ-028 In DROP, imem_ack SHALL discard the data and move to IDLE, or to IDLE with pc updated if a redirect is simultaneous.
REQ-029 A redirect in DROP without ack SHALL update pc and remain in DROP.
REQ-030 instr_valid SHALL never be 1 in IDLE, REQ or DROP.
REQ-031 imem_ack received while imem_req=0 SHALL be ignored.

Reset
REQ-032 While rst=1, the block SHALL set state=IDLE, pc=RESET_PC, imem_req=0, imem_addr=RESET_PC, instr=0, pc_out=0 and instr_valid=0, with rst overriding redirect and ack.
REQ-033 rst asserted mid-request SHALL drop imem_req on the next edge and abandon the request; a late ack SHALL be ignored per REQ-031.
REQ-034 The first imem_req after rst falls SHALL rise one cycle later with imem_addr=RESET_PC.

Verification
REQ-035 Reset, then ack 1 cycle after each req with rdata=32'h2408_0005, and instr_ready held 1 -> instr=32'h2408_0005 and pc_out=32'h3000; the next request is at 32'h3004 and opcode=6'h09.
REQ-036 Hold instr_ready=0 for 5 cycles in HOLD -> instr, pc_out and instr_valid are stable, and imem_req=0 throughout.
REQ-037 Assert redirect with redirect_pc=32'h3043 while in REQ awaiting ack, then ack 3 cycles later -> the data is dropped with no instr_valid, and the next imem_addr is 32'h3040 after one idle cycle.
REQ-038 Assert redirect coincident with imem_ack -> instr_valid stays 0 and the next request is at the redirect target.
REQ-039 Force pc to 32'hFFFF_FFFC via redirect, then fetch -> pc_out=32'hFFFF_FFFC and the next imem_addr is 32'h0000_0000.
REQ-040 Assert rst while imem_req=1, then ack the cycle after -> imem_req=0 and instr_valid=0 with the ack ignored, and after rst falls imem_addr=32'h3000.

Source files
------------

// File: rtl/fetch_unit_if.sv
// Fetch unit bus bundle: instruction-memory request/response, decode-side
// instruction handshake and the branch/jump redirect input.
interface fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [31:0] pc_out;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic        instr_valid;
  logic        instr_ready;
  logic        redirect;
  logic [31:0] redirect_pc;

  // Fetch unit side
  modport master (
    output imem_req, imem_addr, instr, pc_out, opcode, funct, instr_valid,
    input  imem_ack, imem_rdata, instr_ready, redirect, redirect_pc
  );

  // Memory / decode / branch-resolution side
  modport slave (
    input  imem_req, imem_addr, instr, pc_out, opcode, funct, instr_valid,
    output imem_ack, imem_rdata, instr_ready, redirect, redirect_pc
  );
endinterface

// File: rtl/fetch_unit.sv
// Single-outstanding instruction fetch unit. Issues one memory read at a
// time, holds the returned word for decode, and handles redirects in any
// state (a request already on the bus is allowed to finish and is then
// discarded).
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input logic         clk,
  input logic         rst,
  fetch_unit_if.master bus
);

  typedef enum logic [1:0] {IDLE, REQ, HOLD, DROP} stateT;

  stateT       state, stateNext;
  logic [31:0] pc, pcNext;
  logic [31:0] reqAddr, reqAddrNext;
  logic [31:0] instrReg, instrNext;
  logic [31:0] pcOutReg, pcOutNext;
  logic        reqReg, reqNext;
  logic        validReg, validNext;
  logic [31:0] redirectTarget;

  assign redirectTarget  = {bus.redirect_pc[31:2], 2'b00};

  assign bus.imem_req    = reqReg;
  assign bus.imem_addr   = reqAddr;
  assign bus.instr       = instrReg;
  assign bus.pc_out      = pcOutReg;
  assign bus.instr_valid = validReg;
  assign bus.opcode      = instrReg[31:26];
  assign bus.funct       = instrReg[5:0];

  // State and datapath registers; reset overrides redirect and ack.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      pc       <= RESET_PC;
      reqReg   <= 1'b0;
      reqAddr  <= RESET_PC;
      instrReg <= '0;
      pcOutReg <= '0;
      validReg <= 1'b0;
    end else begin
      state    <= stateNext;
      pc       <= pcNext;
      reqReg   <= reqNext;
      reqAddr  <= reqAddrNext;
      instrReg <= instrNext;
      pcOutReg <= pcOutNext;
      validReg <= validNext;
    end
  end

  // Next-state and next-register values; redirect is tested first everywhere.
  always_comb begin
    stateNext   = state;
    pcNext      = pc;
    reqNext     = reqReg;
    reqAddrNext = reqAddr;
    instrNext   = instrReg;
    pcOutNext   = pcOutReg;
    validNext   = validReg;
    case (state)
      IDLE: begin
        if (bus.redirect) begin
          pcNext = redirectTarget;
        end else begin
          reqNext     = 1'b1;
          reqAddrNext = pc;
          stateNext   = REQ;
        end
      end
      REQ: begin
        if (bus.redirect) begin
          pcNext = redirectTarget;
          if (bus.imem_ack) begin
            reqNext   = 1'b0;
            stateNext = IDLE;
          end else begin
            stateNext = DROP;
          end
        end else if (bus.imem_ack) begin
          instrNext = bus.imem_rdata;
          pcOutNext = pc;
          validNext = 1'b1;
          pcNext    = pc + 32'd4;
          reqNext   = 1'b0;
          stateNext = HOLD;
        end
      end
      HOLD: begin
        // A redirect coinciding with the handshake still consumes the word.
        if (bus.redirect) begin
          validNext = 1'b0;
          pcNext    = redirectTarget;
          stateNext = IDLE;
        end else if (validReg && bus.instr_ready) begin
          validNext   = 1'b0;
          reqNext     = 1'b1;
          reqAddrNext = pc;
          stateNext   = REQ;
        end
      end
      DROP: begin
        if (bus.redirect) begin
          pcNext = redirectTarget;
        end
        if (bus.imem_ack) begin
          reqNext   = 1'b0;
          stateNext = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit: directed scenario tasks followed by a randomized
// run checked against a transaction-level scoreboard.
module tb_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_3000;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  fetch_unit_if bus ();

  fetch_unit #(.RESET_PC(RST_PC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic ack, input logic [31:0] rdata, input logic rdy,
                       input logic redir, input logic [31:0] rpc);
    bus.imem_ack    = ack;
    bus.imem_rdata  = rdata;
    bus.instr_ready = rdy;
    bus.redirect    = redir;
    bus.redirect_pc = rpc;
  endtask

  task automatic doReset();
    rst = 1'b1;
    drive(1'b0, '0, 1'b0, 1'b0, '0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    drive(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b1, 32'h0000_1234);
    repeat (3) @(negedge clk);
    checks++; if (bus.imem_req !== 1'b0) begin failures++; $display("FAIL reset_req got=%0b exp=0", bus.imem_req); end
    checks++; if (bus.imem_addr !== RST_PC) begin failures++; $display("FAIL reset_addr got=%h exp=%h", bus.imem_addr, RST_PC); end
    checks++; if (bus.instr !== 32'h0) begin failures++; $display("FAIL reset_instr got=%h exp=0", bus.instr); end
    checks++; if (bus.pc_out !== 32'h0) begin failures++; $display("FAIL reset_pcout got=%h exp=0", bus.pc_out); end
    checks++; if (bus.instr_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b exp=0", bus.instr_valid); end
    rst = 1'b0;
    drive(1'b0, '0, 1'b1, 1'b0, '0);
    @(negedge clk);
    checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== RST_PC) begin failures++; $display("FAIL first_req got=%0b/%h exp=1/%h", bus.imem_req, bus.imem_addr, RST_PC); end
  endtask

  task automatic test_basic();
    @(negedge clk);
    checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h3000) begin failures++; $display("FAIL basic_req got=%0b/%h exp=1/3000", bus.imem_req, bus.imem_addr); end
    drive(1'b1, 32'h2408_0005, 1'b1, 1'b0, '0);
    @(negedge clk);
    drive(1'b0, '0, 1'b1, 1'b0, '0);
    checks++; if (bus.instr_valid !== 1'b1) begin failures++; $display("FAIL basic_valid got=%0b exp=1", bus.instr_valid); end
    checks++; if (bus.instr !== 32'h2408_0005) begin failures++; $display("FAIL basic_instr got=%h exp=24080005", bus.instr); end
    checks++; if (bus.pc_out !== 32'h3000) begin failures++; $display("FAIL basic_pcout got=%h exp=3000", bus.pc_out); end
    checks++; if (bus.opcode !== 6'h09 || bus.funct !== 6'h05) begin failures++; $display("FAIL basic_fields got=%h/%h exp=09/05", bus.opcode, bus.funct); end
    checks++; if (bus.imem_req !== 1'b0) begin failures++; $display("FAIL basic_req_low got=%0b exp=0", bus.imem_req); end
    @(negedge clk);
    checks++; if (bus.instr_valid !== 1'b0 || bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h3004) begin failures++; $display("FAIL basic_next got=%0b/%0b/%h exp=0/1/3004", bus.instr_valid, bus.imem_req, bus.imem_addr); end
  endtask

  task automatic test_hold_stall();
    drive(1'b1, 32'hA5A5_1234, 1'b0, 1'b0, '0);
    @(negedge clk);
    drive(1'b0, '0, 1'b0, 1'b0, '0);
    checks++; if (bus.instr_valid !== 1'b1 || bus.instr !== 32'hA5A5_1234 || bus.pc_out !== 32'h3004) begin failures++; $display("FAIL hold_first got=%0b/%h/%h exp=1/a5a51234/3004", bus.instr_valid, bus.instr, bus.pc_out); end
    for (int unsigned i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++; if (bus.instr_valid !== 1'b1 || bus.instr !== 32'hA5A5_1234 || bus.pc_out !== 32'h3004 || bus.imem_req !== 1'b0) begin
        failures++; $display("FAIL hold_stable cyc=%0d got=%0b/%h/%h/%0b exp=1/a5a51234/3004/0", i, bus.instr_valid, bus.instr, bus.pc_out, bus.imem_req);
      end
    end
    bus.instr_ready = 1'b1;
    @(negedge clk);
    checks++; if (bus.instr_valid !== 1'b0 || bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h3008) begin failures++; $display("FAIL hold_release got=%0b/%0b/%h exp=0/1/3008", bus.instr_valid, bus.imem_req, bus.imem_addr); end
  endtask

  task automatic test_redirect_drop();
    drive(1'b0, '0, 1'b1, 1'b1, 32'h0000_3043);
    for (int unsigned i = 1; i <= 3; i++) begin
      @(negedge clk);
      bus.redirect = 1'b0;
      checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h3008 || bus.instr_valid !== 1'b0) begin
        failures++; $display("FAIL drop_wait cyc=%0d got=%0b/%h/%0b exp=1/3008/0", i, bus.imem_req, bus.imem_addr, bus.instr_valid);
      end
    end
    drive(1'b1, 32'hBAD0_BAD0, 1'b1, 1'b0, '0);
    @(negedge clk);
    drive(1'b0, '0, 1'b1, 1'b0, '0);
    checks++; if (bus.imem_req !== 1'b0 || bus.instr_valid !== 1'b0) begin failures++; $display("FAIL drop_idle got=%0b/%0b exp=0/0", bus.imem_req, bus.instr_valid); end
    @(negedge clk);
    checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h3040 || bus.instr_valid !== 1'b0) begin failures++; $display("FAIL drop_refetch got=%0b/%h/%0b exp=1/3040/0", bus.imem_req, bus.imem_addr, bus.instr_valid); end
  endtask

  task automatic test_redirect_ack();
    drive(1'b1, 32'h1111_2222, 1'b1, 1'b1, 32'h0000_5000);
    @(negedge clk);
    drive(1'b0, '0, 1'b1, 1'b0, '0);
    checks++; if (bus.imem_req !== 1'b0 || bus.instr_valid !== 1'b0) begin failures++; $display("FAIL redack_idle got=%0b/%0b exp=0/0", bus.imem_req, bus.instr_valid); end
    @(negedge clk);
    checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h5000 || bus.instr_valid !== 1'b0) begin failures++; $display("FAIL redack_refetch got=%0b/%h/%0b exp=1/5000/0", bus.imem_req, bus.imem_addr, bus.instr_valid); end
  endtask

  task automatic test_wrap();
    drive(1'b0, '0, 1'b1, 1'b1, 32'hFFFF_FFFF);
    @(negedge clk);
    drive(1'b1, 32'h3333_4444, 1'b1, 1'b0, '0);
    checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h5000) begin failures++; $display("FAIL wrap_drop got=%0b/%h exp=1/5000", bus.imem_req, bus.imem_addr); end
    @(negedge clk);
    drive(1'b0, '0, 1'b1, 1'b0, '0);
    @(negedge clk);
    checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_req got=%0b/%h exp=1/fffffffc", bus.imem_req, bus.imem_addr); end
    drive(1'b1, 32'h0C00_0ABC, 1'b1, 1'b0, '0);
    @(negedge clk);
    drive(1'b0, '0, 1'b1, 1'b0, '0);
    checks++; if (bus.instr_valid !== 1'b1 || bus.pc_out !== 32'hFFFF_FFFC || bus.instr !== 32'h0C00_0ABC) begin failures++; $display("FAIL wrap_instr got=%0b/%h/%h exp=1/fffffffc/0c000abc", bus.instr_valid, bus.pc_out, bus.instr); end
    @(negedge clk);
    checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0000_0000) begin failures++; $display("FAIL wrap_next got=%0b/%h exp=1/0", bus.imem_req, bus.imem_addr); end
  endtask

  task automatic test_reset_midreq();
    rst = 1'b1;
    @(negedge clk);
    checks++; if (bus.imem_req !== 1'b0 || bus.instr_valid !== 1'b0 || bus.imem_addr !== RST_PC) begin failures++; $display("FAIL rstreq_drop got=%0b/%0b/%h exp=0/0/%h", bus.imem_req, bus.instr_valid, bus.imem_addr, RST_PC); end
    rst = 1'b0;
    drive(1'b1, 32'h7777_7777, 1'b1, 1'b0, '0);
    @(negedge clk);
    drive(1'b0, '0, 1'b1, 1'b0, '0);
    checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== RST_PC || bus.instr_valid !== 1'b0) begin failures++; $display("FAIL rstreq_refetch got=%0b/%h/%0b exp=1/%h/0", bus.imem_req, bus.imem_addr, bus.instr_valid, RST_PC); end
    @(negedge clk);
    checks++; if (bus.imem_req !== 1'b1 || bus.instr_valid !== 1'b0) begin failures++; $display("FAIL rstreq_lateack got=%0b/%0b exp=1/0", bus.imem_req, bus.instr_valid); end
  endtask

  // Scoreboard: tracks which address the next fresh request must carry and
  // which word (if any) decode should currently be seeing.
  task automatic test_random();
    logic        expValid    = 1'b0;
    logic [31:0] expInstr    = '0;
    logic [31:0] expPcOut    = '0;
    logic [31:0] expNextAddr = RST_PC;
    logic [31:0] curAddr     = '0;
    logic        curDropped  = 1'b0;
    logic        prevReq     = 1'b0;
    logic        prevAccept  = 1'b0;
    int          stall       = 0;
    logic        ack, rdy, redir, newReq;
    logic [31:0] rdata, rpc;
    doReset();
    for (int unsigned cyc = 0; cyc < 3000; cyc++) begin
      if (cyc != 0) @(negedge clk);
      newReq = bus.imem_req && (!prevReq || prevAccept);
      checks++; if (bus.instr_valid !== expValid) begin failures++; $display("FAIL rnd_valid cyc=%0d got=%0b exp=%0b", cyc, bus.instr_valid, expValid); end
      if (expValid) begin
        checks++; if (bus.instr !== expInstr || bus.pc_out !== expPcOut) begin failures++; $display("FAIL rnd_instr cyc=%0d got=%h@%h exp=%h@%h", cyc, bus.instr, bus.pc_out, expInstr, expPcOut); end
        checks++; if (bus.opcode !== expInstr[31:26] || bus.funct !== expInstr[5:0]) begin failures++; $display("FAIL rnd_fields cyc=%0d got=%h/%h exp=%h/%h", cyc, bus.opcode, bus.funct, expInstr[31:26], expInstr[5:0]); end
      end
      if (newReq) begin
        checks++; if (bus.imem_addr !== expNextAddr) begin failures++; $display("FAIL rnd_reqaddr cyc=%0d got=%h exp=%h", cyc, bus.imem_addr, expNextAddr); end
        curAddr    = expNextAddr;
        curDropped = 1'b0;
        stall      = 0;
      end else if (bus.imem_req) begin
        checks++; if (bus.imem_addr !== curAddr) begin failures++; $display("FAIL rnd_addrstable cyc=%0d got=%h exp=%h", cyc, bus.imem_addr, curAddr); end
      end
      checks++; if (bus.imem_req && bus.instr_valid) begin failures++; $display("FAIL rnd_overlap cyc=%0d got=req&valid exp=exclusive", cyc); end

      stall++;
      if (stall > 200) begin
        failures++; $display("FAIL rnd_timeout cyc=%0d got=no_progress exp=progress_within_200", cyc);
        break;
      end

      ack   = bus.imem_req ? ($urandom_range(99) < 40) : ($urandom_range(99) < 5);
      rdata = $urandom;
      rdy   = $urandom_range(1);
      redir = ($urandom_range(99) < 8);
      rpc   = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
      drive(ack, rdata, rdy, redir, rpc);

      if (expValid && rdy) stall = 0;
      if (expValid && rdy) expValid = 1'b0;
      if (bus.imem_req && ack && !curDropped && !redir) begin
        expValid    = 1'b1;
        expInstr    = rdata;
        expPcOut    = curAddr;
        expNextAddr = curAddr + 32'd4;
      end
      if (redir) begin
        expValid    = 1'b0;
        expNextAddr = {rpc[31:2], 2'b00};
        if (bus.imem_req) curDropped = 1'b1;
      end
      prevReq    = bus.imem_req;
      prevAccept = bus.imem_req && ack;
    end
    @(negedge clk);
    drive(1'b0, '0, 1'b0, 1'b0, '0);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    drive(1'b0, '0, 1'b0, 1'b0, '0);
    test_reset();
    test_basic();
    test_hold_stall();
    test_redirect_drop();
    test_redirect_ack();
    test_wrap();
    test_reset_midreq();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
